fcvt_s_int_pipe: RTL
====================

Name: fcvt_s_int_pipe

Overview:
- Pipelined integer-to-single-precision converter for the FPU datapath; successor to the combinational word-to-float converter.
- Generalised to XLEN 32/64 sources with a per-operation signed/unsigned mode.
- Supports all RISC-V static rounding modes and the inexact flag.
- Valid/ready handshake on both sides, plus a pass-through tag for destination-register tracking.

Parameters:
- XLEN, 32, source integer width; legal values 32 or 64.
- TAG_W, 5, width of the opaque tag carried alongside each operation (rd index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  converter can accept; transfer when in_valid && in_ready.
- in_data  in  XLEN  integer source (rs1).
- in_signed  in  1  1 = two's-complement source (FCVT.S.W/L), 0 = unsigned (FCVT.S.WU/LU).
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
- in_tag  in  TAG_W  pass-through tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_data  out  32  IEEE-754 binary32 result.
- out_nx  out  1  inexact flag (NX) for this result.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset:
  - All stage valid bits clear: out_valid=0.
  - out_data, out_nx and out_tag reset to 0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; no result is emitted for it.
- Pipeline: three registered stages, latency exactly 3 cycles from input transfer to out_valid when not stalled. Throughput is one per cycle.
  - S1, sign/magnitude:
    - sign = in_signed & in_data[XLEN-1].
    - mag = sign ? (~in_data + 1) : in_data, XLEN bits unsigned.
    - Signed minimum (0x80000000 / 0x8000...0) yields mag = 2^(XLEN-1), correct as unsigned.
    - Register sign, mag, rm, tag and zero = (mag == 0).
  - S2, normalise:
    - lz = leading-zero count of mag.
    - norm = mag << lz, so the MSB is at bit XLEN-1.
    - exp = 127 + (XLEN-1-lz), 8 bits; never overflows for XLEN<=64.
  - S3, round and pack:
    - mant = norm[XLEN-2 : XLEN-24]; G = norm[XLEN-25]; sticky = OR of norm[XLEN-26:0].
    - Define rbits = {G, sticky}; inexact = G|sticky.
    - Round-up increment:
      - RNE: G & (sticky | mant[0]).
      - RTZ: 0.
      - RDN: sign & inexact.
      - RUP: ~sign & inexact.
      - RMM: G.
    - {exp, mant} + inc as a 31-bit add; mantissa carry-out propagates into the exponent (e.g. 2^32-1 RNE -> exponent 159, mantissa 0).
    - out_data = {sign, exp, mant}; out_nx = inexact.
  - Zero input: out_data = 0x00000000 (never -0), out_nx = 0, for any rm and signedness.
- Handshake and stall:
  - advance = ~out_valid | out_ready.
  - All three stages shift together only when advance=1; in_ready = advance (combinational from out_valid, out_ready).
  - While stalled (out_valid & ~out_ready): out_data, out_nx and out_tag hold stable, all stage registers hold, and in_data is ignored.
  - A bubble (in_valid=0 while advancing) propagates as a cleared stage valid bit.
  - Simultaneous output transfer and input transfer in the same cycle is legal and loses nothing.
- No exceptions other than NX are raised: integer-to-binary32 can neither overflow nor underflow.

Test Plan:
- XLEN=32, signed: 0x00000001 RNE -> 0x3F800000, nx=0, appears exactly 3 cycles after acceptance; 0xFFFFFFFF -> 0xBF800000, nx=0; 0x80000000 -> 0xCF000000, nx=0.
- Unsigned: 0xFFFFFFFF RNE -> 0x4F800000, nx=1; RTZ -> 0x4F7FFFFF, nx=1; 0x00000000 with RDN, signed -> 0x00000000, nx=0.
- Rounding ties: 0x01000001 unsigned RNE -> 0x4B800000, nx=1; RUP -> 0x4B800001; RMM -> 0x4B800001; signed 0xFEFFFFFF (-16777217) RDN -> 0xCB800001, RUP -> 0xCB800000.
- Back-pressure: issue 5 back-to-back operations with tags 1..5 while out_ready is held 0 from cycle 4 to cycle 8. Required: in_ready=0 during the stall, out_data and out_tag stable, results in order 1..5, none lost or duplicated, one per cycle after release.
- Reset mid-operation: accept 3 operations, assert reset for 1 cycle. Required: out_valid=0 and out_data=0 next cycle, no stale result emitted afterwards, and in_ready=1 after reset.
- XLEN=64, unsigned: 0xFFFFFFFFFFFFFFFF RNE -> 0x5F800000, nx=1; 0x0000000100000000 -> 0x4F800000, nx=0.

Source files
------------

// File: rtl/fcvt_s_int_pipe.sv
// fcvt_s_int_pipe: three-stage XLEN integer to binary32 converter with valid/ready handshake and NX flag
module fcvt_s_int_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_nx,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LZW = $clog2(XLEN);

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic            sign_c;
    logic [XLEN-1:0] mag_c;
    assign sign_c = in_signed & in_data[XLEN-1];
    assign mag_c  = sign_c ? ~in_data + 1'b1 : in_data;

    logic             v1, sign1, zero1;
    logic [XLEN-1:0]  mag1;
    logic [2:0]       rm1;
    logic [TAG_W-1:0] tag1;

    logic [LZW-1:0]  lz;
    logic [XLEN-2:0] frac_c;
    logic [7:0]      exp_c;
    always_comb begin
        lz = '0;
        for (int i = 0; i < XLEN; i++)
            if (mag1[i]) lz = LZW'(XLEN - 1 - i);
    end
    // The leading one is implicit, so only the bits below it are kept.
    assign frac_c = mag1[XLEN-2:0] << lz;
    assign exp_c  = 8'(127 + XLEN - 1) - 8'(lz);

    logic             v2, sign2, zero2;
    logic [XLEN-2:0]  frac2;
    logic [7:0]       exp2;
    logic [2:0]       rm2;
    logic [TAG_W-1:0] tag2;

    logic [22:0] mant;
    logic        g, sticky, nx_c, inc_c;
    logic [30:0] sum_c;
    assign mant   = frac2[XLEN-2 -: 23];
    assign g      = frac2[XLEN-25];
    assign sticky = |frac2[XLEN-26:0];
    assign nx_c   = g | sticky;
    assign inc_c  = rm2 == 3'd1 ? 1'b0 :
                    rm2 == 3'd2 ? sign2 & nx_c :
                    rm2 == 3'd3 ? ~sign2 & nx_c :
                    rm2 == 3'd4 ? g :
                                  g & (sticky | mant[0]);
    // Mantissa carry-out ripples into the exponent field.
    assign sum_c  = {exp2, mant} + 31'(inc_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            {v1, sign1, zero1, mag1, rm1, tag1} <= '0;
            {v2, sign2, zero2, frac2, exp2, rm2, tag2} <= '0;
            {out_valid, out_data, out_nx, out_tag} <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            sign1     <= sign_c;
            mag1      <= mag_c;
            zero1     <= mag_c == '0;
            rm1       <= in_rm;
            tag1      <= in_tag;
            v2        <= v1;
            sign2     <= sign1;
            zero2     <= zero1;
            frac2     <= frac_c;
            exp2      <= exp_c;
            rm2       <= rm1;
            tag2      <= tag1;
            out_valid <= v2;
            out_data  <= zero2 ? 32'h0 : {sign2, sum_c};
            out_nx    <= zero2 ? 1'b0 : nx_c;
            out_tag   <= tag2;
        end
    end
endmodule
